// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StArb,
        StIssue,
        StWaitStart,
        StWaitEnd
    } arb_state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = uart_arb_pkg::ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o
);

    localparam logic [PTR_W:0] NW = (PTR_W + 1)'(N_REQ);

    logic [PTR_W:0] idx;
    logic           found;

    // ptr_i + N_REQ always fits in PTR_W+1 bits, so one conditional subtract wraps it.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (idx >= NW) begin
                idx = idx - NW;
            end
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                gnt_o[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmitter among N_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to force-release an owner that stalls mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               uart_e_o,
    output logic [7:0]         uart_d_o,
    input  logic               uart_busy_i,
    output logic               abort_o
);

    localparam int unsigned PtrW = ptr_width(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic             last_q, last_d;

    logic [N_REQ-1:0] pick;
    logic             any_valid;
    logic [PtrW-1:0]  owner_idx;
    logic [7:0]       owner_data;
    logic             owner_valid;
    logic             owner_last;
    logic             fire;
    logic             expire;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PtrW)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick),
        .valid_o (any_valid)
    );

    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant_q[k]) begin
                owner_idx  = PtrW'(k);
                owner_data = req_data_i[8*k +: 8];
            end
        end
    end

    assign owner_valid = |(req_valid_i & grant_q);
    assign owner_last  = |(req_last_i & grant_q);
    assign fire        = (state_q == StIssue) && owner_valid && !uart_busy_i;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        uart_e_o    = 1'b0;
        uart_d_o    = '0;
        req_ready_o = '0;
        unique case (state_q)
            StArb: begin
                if (any_valid) begin
                    grant_d = pick;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (fire) begin
                    uart_e_o    = 1'b1;
                    uart_d_o    = owner_data;
                    req_ready_o = grant_q;
                    last_d      = owner_last;
                    state_d     = StWaitStart;
                end else if (expire) begin
                    grant_d = '0;
                    ptr_d   = owner_idx;
                    state_d = StArb;
                end
            end
            StWaitStart: begin
                if (uart_busy_i) begin
                    state_d = StWaitEnd;
                end
            end
            StWaitEnd: begin
                if (!uart_busy_i) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_idx;
                        state_d = StArb;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StArb;
            grant_q <= '0;
            ptr_q   <= PtrW'(N_REQ - 1);
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sent_q, sent_d;
    logic            abort_q;

    // Only an owner that has already started its packet can be timed out.
    assign expire = (state_q == StIssue) && sent_q && !owner_valid &&
                    (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sent_d = sent_q;
        if (state_q == StArb) begin
            cnt_d  = '0;
            sent_d = 1'b0;
        end else if (fire) begin
            cnt_d  = '0;
            sent_d = 1'b1;
        end else if ((state_q == StIssue) && sent_q && !owner_valid) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            sent_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            abort_q <= expire;
        end
    end

    assign abort_o = abort_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign abort_o        = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among N byte-stream requesters. Grants the UART round-robin and holds the grant for a whole packet, up to and including the byte flagged last. Drives the transmitter's enable/data inputs and tracks its busy output, so each byte is issued only when the transmitter is idle. Sits between the on-chip message sources (debug, status, log) and the single tx pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, mid-packet idle limit before forced release (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
req_valid_i  input  N_REQ  per-requester byte valid
req_data_i  input  8*N_REQ  per-requester byte; requester k at bits [8k+7:8k]
req_last_i  input  N_REQ  byte is the last of its packet
req_ready_o  output  N_REQ  byte accepted this cycle (combinational, one-hot)
grant_o  output  N_REQ  registered one-hot current owner; 0 when idle
uart_e_o  output  1  start-transmit pulse to the transmitter
uart_d_o  output  8  byte to the transmitter; valid while uart_e_o=1
uart_busy_i  input  1  transmitter busy (low only when the transmitter is idle)
abort_o  output  1  one-cycle pulse on forced packet release; tied 0 without the macro

Behaviour:
- Reset (resetn=0 at a clk edge): state ARB, grant_o=0, last-grant pointer=N_REQ-1 (requester 0 has first priority), captured last flag=0, abort_o=0. Combinational outputs req_ready_o, uart_e_o and uart_d_o evaluate to 0 in ARB.
- States: ARB, ISSUE, WAIT_START, WAIT_END.
- ARB: if any req_valid_i is set, pick the first set bit searching upward from pointer+1, with wrap-around. Register grant_o to that one-hot and go to ISSUE. Nothing is accepted in ARB.
- ISSUE (owner g): when req_valid_i[g]=1 and uart_busy_i=0, in the same cycle: uart_e_o=1, uart_d_o=req_data_i[g], req_ready_o[g]=1. Capture req_last_i[g] and go to WAIT_START. Otherwise stay in ISSUE with all three outputs 0.
- Valid from non-owners is ignored in ISSUE and never stalls the owner.
- WAIT_START: stay until uart_busy_i=1, then go to WAIT_END. With the transmitter this is one cycle.
- WAIT_END: stay until uart_busy_i=0. Then:
  - if the captured last flag is 1: clear grant_o, set pointer=g, go to ARB;
  - else go to ISSUE, keeping the grant.
- Latency from idle: valid in cycle 0 -> grant_o in cycle 1 -> uart_e_o/req_ready_o in cycle 1, combinationally, if valid is held and the UART is idle.
- Between packets the arbiter spends one cycle in ARB. Back-to-back bytes inside a packet issue on the first cycle busy drops.
- Owner dropping valid mid-packet: grant is held indefinitely (unless the macro is enabled).
- Owner deasserting valid in the same cycle that busy drops: no byte issued; wait in ISSUE.
- Only one req_ready_o bit is ever high, and only when uart_e_o=1.
- Reset mid-packet: grant is lost. The transmitter shares resetn, so no partial byte remains.

Optional Feature:
UART_ARB_TIMEOUT_EN
- With the macro: a counter runs in ISSUE while at least one byte of the current packet has been sent and req_valid_i[g]=0. It clears when a byte is accepted.
- When the counter reaches TIMEOUT_CYCLES: pulse abort_o for one cycle, clear grant_o, set pointer=g, go to ARB.
- Without the macro: no counter is built, abort_o is constant 0, and the grant is held forever.

Decomposition:
- Package uart_arb_pkg: state localparams (ARB, ISSUE, WAIT_START, WAIT_END), pointer width function (clog2 of N_REQ).
- Sub-module rr_arbiter: combinational round-robin picker; inputs request vector and pointer, outputs one-hot grant and any-valid. Reused by the other arbitration blocks in the codebase.

Test Plan:
Bench instantiates the arbiter driving the transmitter with CLKS_PER_BIT=4.
1. Requester 0 sends 0xA5 with last=1 -> grant_o=0001 and one uart_e_o pulse with uart_d_o=0xA5; serial line shows 0xA5; grant_o=0 after stop bit.
2. Requesters 0 and 2 both valid from reset, single bytes 0x11 and 0x22 -> 0x11 sent first, then 0x22; pointer ends at 2.
3. Requester 1 sends a 3-byte packet 0x01,0x02,0x03 while requester 0 is valid -> all 3 bytes go out contiguously before requester 0 is granted.
4. All 4 requesters continuously valid, single-byte packets -> grant order 0,1,2,3,0,1; no requester starves.
5. resetn pulsed low during the second data bit -> grant_o=0 and state ARB next cycle; requester 0 wins the next arbitration.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20: owner stops after byte 1 of 2 -> abort_o pulses for one cycle 20 cycles after the UART goes idle; grant passes to the next valid requester.
